imem_arbiter: RTL and testbench

// - Shares the single-port instruction RAM (1-cycle read latency) between the IF fetch path and a

---
 rtl/imem_arbiter_pkg.sv | 18 +
 rtl/imem_arbiter_if.sv | 38 +++
 rtl/imem_arbiter_starve_counter.sv | 29 ++
 rtl/imem_arbiter.sv | 103 ++++++++++
 tb/tb_imem_arbiter.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/imem_arbiter_pkg.sv
// Shared types and defaults for the instruction-RAM arbiter.
package imem_arbiter_pkg;

   localparam int ADDR_W_DEF     = 10;
   localparam int DATA_W_DEF     = 32;
   localparam int STARVE_MAX_DEF = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      L_ISSUE = 2'd1,
      L_RESP  = 2'd2
   } arb_state_e;

   function automatic int starve_w(input int max_cnt);
      return (max_cnt < 1) ? 1 : $clog2(max_cnt + 1);
   endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Fetch, loader and RAM-side signals of the instruction-RAM arbiter.
interface imem_arbiter_if
   import imem_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic              f_req;
   logic [DATA_W-1:0] f_addr;
   logic [DATA_W-1:0] f_instr;
   logic              f_valid;
   logic              f_stall;

   logic              l_req;
   logic              l_we;
   logic [ADDR_W-1:0] l_addr;
   logic [DATA_W-1:0] l_wdata;
   logic              l_ack;
   logic [DATA_W-1:0] l_rdata;

   logic              ram_ena;
   logic              ram_wea;
   logic [ADDR_W-1:0] ram_addra;
   logic [DATA_W-1:0] ram_dina;
   logic [DATA_W-1:0] ram_douta;

   modport slave (
      input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, ram_douta,
      output f_instr, f_valid, f_stall, l_ack, l_rdata,
             ram_ena, ram_wea, ram_addra, ram_dina
   );

   modport master (
      output f_req, f_addr, l_req, l_we, l_addr, l_wdata, ram_douta,
      input  f_instr, f_valid, f_stall, l_ack, l_rdata,
             ram_ena, ram_wea, ram_addra, ram_dina
   );
endinterface

// File: rtl/imem_arbiter_starve_counter.sv
// Saturating wait counter that bounds how long the loader can be held off by fetch.
module imem_arbiter_starve_counter
   import imem_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic at_max
);
   localparam int          W   = starve_w(STARVE_MAX);
   localparam logic [W-1:0] MAX = W'(STARVE_MAX);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else if (clr)
         cnt_q <= '0;
      else if (inc && (cnt_q != MAX))
         cnt_q <= cnt_q + W'(1);
   end

   assign at_max = (cnt_q == MAX);

endmodule

// File: rtl/imem_arbiter.sv
// Shares the single-port instruction RAM between IF fetch (priority) and the loader port,
// with a bounded-wait forced loader grant and an IF stall/hold path.
module imem_arbiter
   import imem_arbiter_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input logic           clk,
   input logic           rst,
   imem_arbiter_if.slave bus
);
   arb_state_e        state_q, state_d, state;
   logic              l_gnt, f_gnt;
   logic              at_max, starve_inc, starve_clr;
   logic              f_vld_q;
   logic [DATA_W-1:0] hold_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] din_q;
   logic              unused_f_addr;

   assign unused_f_addr = ^{bus.f_addr[DATA_W-1:ADDR_W+2], bus.f_addr[1:0]};

   // The loader issues in the same cycle it wins, so L_ISSUE is this cycle's resolved
   // state rather than a registered one; fetch never loses a slot to a dead grant cycle.
   always_comb begin
      state   = state_q;
      state_d = state_q;
      l_gnt   = 1'b0;
      f_gnt   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.l_req && (!bus.f_req || at_max)) begin
               l_gnt   = 1'b1;
               state   = L_ISSUE;
               state_d = L_RESP;
            end else begin
               f_gnt = bus.f_req;
            end
         end
         L_RESP: begin
            f_gnt   = bus.f_req;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (rst) begin
         l_gnt = 1'b0;
         f_gnt = 1'b0;
         state = IDLE;
      end
   end

   assign starve_clr = !bus.l_req || l_gnt;
   assign starve_inc = bus.l_req && !l_gnt && (state_q != L_RESP);

   imem_arbiter_starve_counter #(.STARVE_MAX(STARVE_MAX)) u_starve (
      .clk    (clk),
      .rst    (rst),
      .inc    (starve_inc),
      .clr    (starve_clr),
      .at_max (at_max)
   );

   // Address/data lines park on their last driven value when nobody is granted.
   always_comb begin
      bus.ram_ena   = l_gnt | f_gnt;
      bus.ram_wea   = l_gnt & bus.l_we;
      bus.ram_addra = addr_q;
      bus.ram_dina  = din_q;
      if (l_gnt) begin
         bus.ram_addra = bus.l_addr;
         bus.ram_dina  = bus.l_wdata;
      end else if (f_gnt) begin
         bus.ram_addra = bus.f_addr[ADDR_W+1:2];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         f_vld_q <= 1'b0;
         hold_q  <= '0;
         addr_q  <= '0;
         din_q   <= '0;
      end else begin
         state_q <= state_d;
         f_vld_q <= f_gnt;
         if (f_vld_q)
            hold_q <= bus.ram_douta;
         addr_q  <= bus.ram_addra;
         din_q   <= bus.ram_dina;
      end
   end

   assign bus.f_valid = f_vld_q;
   assign bus.f_instr = f_vld_q ? bus.ram_douta : hold_q;
   assign bus.f_stall = bus.f_req && (state == L_ISSUE);
   assign bus.l_ack   = (state_q == L_RESP);
   assign bus.l_rdata = bus.l_ack ? bus.ram_douta : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: directed stimulus pushes expectations, a negedge monitor checks them.
module tb_imem_arbiter;
   import imem_arbiter_pkg::*;

   typedef struct packed {
      logic        rd;
      logic [31:0] d;
   } lexp_t;

   logic clk, rst, preload;
   int   n_tests, n_fail, wea_cnt;
   logic [31:0] exp_f[$];
   lexp_t       exp_l[$];
   logic [31:0] mem [0:1023];

   imem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

   imem_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_MAX(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered single-port RAM; a write leaves douta unchanged.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 1024; i++)
            mem[i] <= (i == 0) ? 32'h11 : (i == 1) ? 32'h22 : (i == 2) ? 32'h33 : 32'h100 + 32'(i);
         bus.ram_douta <= '0;
      end else if (bus.ram_ena) begin
         if (bus.ram_wea) mem[bus.ram_addra] <= bus.ram_dina;
         else             bus.ram_douta     <= mem[bus.ram_addra];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin : mon
      logic [31:0] fe;
      lexp_t       le;
      if (bus.ram_wea === 1'b1) wea_cnt++;
      if (bus.f_valid === 1'b1) begin
         if (exp_f.size() == 0) chk("f_valid_unexpected", bus.f_valid, 0);
         else begin
            fe = exp_f.pop_front();
            chk("f_instr", bus.f_instr, fe);
         end
      end
      if (bus.l_ack === 1'b1) begin
         if (exp_l.size() == 0) chk("l_ack_unexpected", bus.l_ack, 0);
         else begin
            le = exp_l.pop_front();
            if (le.rd) chk("l_rdata", bus.l_rdata, le.d);
         end
      end
   end

   task automatic loader_txn(input logic we, input logic [9:0] a, input logic [31:0] wd,
                             input logic [31:0] rd_exp);
      int lat;
      @(posedge clk); #1;
      bus.l_req = 1'b1; bus.l_we = we; bus.l_addr = a; bus.l_wdata = wd;
      exp_l.push_back('{rd: !we, d: rd_exp});
      @(negedge clk);
      chk("ld_issue_ena", bus.ram_ena, 1);
      chk("ld_issue_wea", bus.ram_wea, we);
      chk("ld_issue_addr", bus.ram_addra, a);
      if (we) chk("ld_issue_din", bus.ram_dina, wd);
      lat = -1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.l_ack) begin lat = i; break; end
      end
      chk("ld_ack_latency", lat, 0);
      @(posedge clk); #1;
      bus.l_req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] t3_exp [0:9];
      int pc, idx;
      n_tests = 0; n_fail = 0; wea_cnt = 0;
      rst = 1'b1; preload = 1'b1;
      bus.f_req = 1'b0; bus.f_addr = '0;
      bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_addr = '0; bus.l_wdata = '0;

      // reset state
      @(negedge clk);
      chk("rst_f_valid", bus.f_valid, 0);
      chk("rst_f_stall", bus.f_stall, 0);
      chk("rst_l_ack", bus.l_ack, 0);
      chk("rst_l_rdata", bus.l_rdata, 0);
      chk("rst_ram_ena", bus.ram_ena, 0);
      chk("rst_ram_wea", bus.ram_wea, 0);
      chk("rst_f_instr", bus.f_instr, 0);
      @(posedge clk); #1;
      rst = 1'b0; preload = 1'b0;

      // fetch-only stream
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         bus.f_req  = 1'b1;
         bus.f_addr = 32'(k * 4);
         exp_f.push_back((k == 0) ? 32'h11 : (k == 1) ? 32'h22 : 32'h33);
         @(negedge clk);
         chk("fetch_stall", bus.f_stall, 0);
         chk("fetch_ena", bus.ram_ena, 1);
      end
      @(posedge clk); #1;
      bus.f_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("hold_valid", bus.f_valid, 0);
      chk("hold_instr", bus.f_instr, 32'h33);

      // loader write then read, fetch idle
      loader_txn(1'b1, 10'd5, 32'hDEADBEEF, 32'h0);
      loader_txn(1'b0, 10'd5, 32'h0, 32'hDEADBEEF);
      chk("wea_pulses", wea_cnt, 1);

      // fetch saturates the RAM; loader forced on the 9th cycle
      t3_exp = '{32'h11, 32'h22, 32'h33, 32'h103, 32'h104,
                 32'hDEADBEEF, 32'h106, 32'h107, 32'h108, 32'h109};
      pc = 0; idx = 0;
      for (int k = 0; k < 11; k++) begin
         @(posedge clk); #1;
         bus.f_req  = 1'b1;
         bus.f_addr = 32'(pc * 4);
         if (k == 0) begin
            bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 10'd2;
            exp_l.push_back('{rd: 1'b1, d: 32'h33});
         end
         if (k == 10) bus.l_req = 1'b0;
         if (k != 8) begin exp_f.push_back(t3_exp[idx]); idx++; end
         @(negedge clk);
         chk("starve_stall", bus.f_stall, (k == 8));
         if (k == 8) begin
            chk("starve_issue_addr", bus.ram_addra, 2);
            chk("starve_l_ack_early", bus.l_ack, 0);
         end
         if (k == 9) begin
            chk("starve_resp_valid", bus.f_valid, 0);
            chk("starve_hold_instr", bus.f_instr, 32'h107);
            chk("starve_resp_ack", bus.l_ack, 1);
            chk("starve_resp_fetch_addr", bus.ram_addra, 8);
         end
         if (k != 8) pc++;
      end
      @(posedge clk); #1;
      bus.f_req = 1'b0;

      // write followed directly by a fetch of the same word
      @(posedge clk); #1;
      bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 10'd5; bus.l_wdata = 32'hCAFE0001;
      exp_l.push_back('{rd: 1'b0, d: 32'h0});
      @(negedge clk);
      chk("raw_issue_wea", bus.ram_wea, 1);
      @(posedge clk); #1;
      bus.f_req = 1'b1; bus.f_addr = 32'h14;
      exp_f.push_back(32'hCAFE0001);
      @(negedge clk);
      chk("raw_ack", bus.l_ack, 1);
      chk("raw_fetch_ena", bus.ram_ena, 1);
      chk("raw_fetch_wea", bus.ram_wea, 0);
      chk("raw_fetch_addr", bus.ram_addra, 5);
      @(posedge clk); #1;
      bus.l_req = 1'b0; bus.f_req = 1'b0;
      @(negedge clk);

      // reset during a loader read issue
      @(posedge clk); #1;
      bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 10'd3;
      @(negedge clk);
      chk("rst_mid_issue_ena", bus.ram_ena, 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_ram_ena", bus.ram_ena, 0);
      chk("rst_mid_l_ack", bus.l_ack, 0);
      @(posedge clk); #1;
      bus.l_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rst_no_ack", bus.l_ack, 0);
      end
      chk("rst_hold_cleared", bus.f_instr, 0);
      loader_txn(1'b0, 10'd5, 32'h0, 32'hCAFE0001);

      @(negedge clk);
      @(negedge clk);
      chk("exp_f_drained", exp_f.size(), 0);
      chk("exp_l_drained", exp_l.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
